cache_partition_ctrl: RTL and testbench

- Sequences run-time changes to the dcache unified/scratch set split (`unified_cache_sets`) that the host programs over the DCR bus.
- On a DCR write to `VX_DCR_UNIFIED_CACHE_SETS` it performs these steps in order:
  1. Gates new core dcache requests.
  2. Drains in-flight requests.
  3. Issues a full dcache flush.
  4. Applies the new set count.
  5. Reopens the request path.
- Sits in the socket between the DCR bus and the dcache cluster, and replaces the direct DCR-to-register write path.

---
 rtl/cache_partition_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cache_partition_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_partition_ctrl.sv
// cache_partition_ctrl: sequences run-time changes of the dcache unified/scratch
// set split. A DCR write to the set-count register gates new core requests,
// waits for in-flight requests to drain, flushes the dcache, applies the new
// set count and reopens the request path.
// Optional feature macro: CACHE_PART_PERF_EN (adds reconfig/stall perf counters).
module cache_partition_ctrl #(
    parameter int unsigned NUM_REQS          = 4,
    parameter int unsigned SETS_W            = 12,
    parameter int unsigned MAX_SETS          = 32,
    parameter int unsigned DEFAULT_SETS      = 16,
    parameter int unsigned OUTST_W           = 8,
    parameter int unsigned VX_DCR_ADDR_WIDTH = 12,
    parameter int unsigned VX_DCR_DATA_WIDTH = 32,
    parameter logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_UNIFIED_CACHE_SETS = VX_DCR_ADDR_WIDTH'(6)
`ifdef CACHE_PART_PERF_EN
    ,
    parameter int unsigned PERF_CTR_BITS     = 32
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dcr_write_valid,
    input  logic [VX_DCR_ADDR_WIDTH-1:0] dcr_write_addr,
    input  logic [VX_DCR_DATA_WIDTH-1:0] dcr_write_data,
    input  logic [NUM_REQS-1:0]          req_fire,
    input  logic [NUM_REQS-1:0]          rsp_fire,
    output logic                         req_gate,
    output logic                         flush_valid,
    input  logic                         flush_ready,
    input  logic                         flush_done,
    output logic [SETS_W-1:0]            unified_cache_sets,
    output logic                         busy
`ifdef CACHE_PART_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]     perf_reconfigs,
    output logic [PERF_CTR_BITS-1:0]     perf_stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_DRAIN,
        S_FLUSH,
        S_WAIT,
        S_APPLY
    } state_e;

    state_e              state_q, state_d;
    logic                req_gate_q, req_gate_d;
    logic                pend_q, pend_d;
    logic [SETS_W-1:0]   pend_sets_q, pend_sets_d;
    logic [SETS_W-1:0]   sets_q, sets_d;
    logic [OUTST_W-1:0]  cnt_q, cnt_d;

    logic [OUTST_W:0]    req_pop, rsp_pop, cnt_sum, cnt_next;
    logic                wr_hit;
    logic [SETS_W-1:0]   wr_raw, wr_sets;
    logic                unused_data_bits;

    function automatic logic [OUTST_W:0] popcnt(input logic [NUM_REQS-1:0] v);
        logic [OUTST_W:0] c;
        c = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            c = c + (OUTST_W+1)'(v[i]);
        end
        return c;
    endfunction

    // Outstanding-request accounting and DCR write decode/clamp
    always_comb begin
        req_pop          = popcnt(req_fire);
        rsp_pop          = popcnt(rsp_fire);
        cnt_sum          = {1'b0, cnt_q} + req_pop;
        cnt_next         = cnt_sum - rsp_pop;
        cnt_d            = cnt_next[OUTST_W-1:0];
        wr_hit           = dcr_write_valid && (dcr_write_addr == VX_DCR_UNIFIED_CACHE_SETS);
        wr_raw           = dcr_write_data[SETS_W-1:0];
        wr_sets          = (wr_raw > SETS_W'(MAX_SETS)) ? SETS_W'(MAX_SETS) : wr_raw;
        unused_data_bits = ^dcr_write_data[VX_DCR_DATA_WIDTH-1:SETS_W];
    end

    // Next-state logic: capture, sequencing and apply
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_sets_d = pend_sets_q;
        sets_d      = sets_q;

        if (wr_hit) begin
            pend_d      = 1'b1;
            pend_sets_d = wr_sets;
        end

        case (state_q)
            // A fresh write is acted on in its own cycle so the gate is up one
            // cycle later; an equal value stays pending one cycle and then clears.
            S_IDLE: begin
                if (wr_hit) begin
                    if (wr_sets != sets_q) state_d = S_GATE;
                end else if (pend_q) begin
                    if (pend_sets_q != sets_q) state_d = S_GATE;
                    else                       pend_d  = 1'b0;
                end
            end
            S_GATE:  state_d = S_DRAIN;
            S_DRAIN: begin
                if (cnt_q == '0 && req_fire == '0 && rsp_fire == '0) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_ready) state_d = flush_done ? S_APPLY : S_WAIT;
            end
            S_WAIT: begin
                if (flush_done) state_d = S_APPLY;
            end
            S_APPLY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The set count is loaded on entry to APPLY so it is visible during the
        // APPLY cycle; a write landing on that edge stays pending.
        if (state_d == S_APPLY && state_q != S_APPLY) begin
            sets_d = pend_sets_q;
            pend_d = wr_hit;
        end
    end

    always_comb begin
        req_gate_d = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_gate_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_sets_q <= '0;
            sets_q      <= SETS_W'(DEFAULT_SETS);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_gate_q  <= req_gate_d;
            pend_q      <= pend_d;
            pend_sets_q <= pend_sets_d;
            sets_q      <= sets_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_gate           = req_gate_q;
    assign flush_valid        = (state_q == S_FLUSH);
    assign unified_cache_sets = sets_q;
    assign busy               = (state_q != S_IDLE) || pend_q;

    // The outstanding counter must never wrap in either direction
    assert property (@(posedge clk) disable iff (reset) cnt_sum >= rsp_pop);
    assert property (@(posedge clk) disable iff (reset) (cnt_sum < rsp_pop) || !cnt_next[OUTST_W]);

`ifdef CACHE_PART_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_reconfigs_q, perf_reconfigs_d;
    logic [PERF_CTR_BITS-1:0] perf_stall_q, perf_stall_d;

    // Perf counter increments (wrap naturally)
    always_comb begin
        perf_reconfigs_d = perf_reconfigs_q;
        perf_stall_d     = perf_stall_q;
        if (state_q == S_APPLY) perf_reconfigs_d = perf_reconfigs_q + PERF_CTR_BITS'(1);
        if (req_gate_q)         perf_stall_d     = perf_stall_q + PERF_CTR_BITS'(1);
    end

    // Perf counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_reconfigs_q <= '0;
            perf_stall_q     <= '0;
        end else begin
            perf_reconfigs_q <= perf_reconfigs_d;
            perf_stall_q     <= perf_stall_d;
        end
    end

    assign perf_reconfigs    = perf_reconfigs_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_cache_partition_ctrl.sv
// Testbench for cache_partition_ctrl: directed timing scenarios plus randomized
// writes/traffic/flush timing, with a scoreboard of expected set-count changes.
module tb_cache_partition_ctrl;

    localparam int unsigned NUM_REQS     = 4;
    localparam int unsigned SETS_W       = 12;
    localparam int unsigned MAX_SETS     = 32;
    localparam int unsigned DEFAULT_SETS = 16;
    localparam int unsigned OUTST_W      = 8;
    localparam int unsigned AW           = 12;
    localparam int unsigned DW           = 32;
    localparam logic [AW-1:0] SET_ADDR   = 12'h006;
`ifdef CACHE_PART_PERF_EN
    localparam int unsigned PCB          = 16;
`endif

    logic                clk;
    logic                reset;
    logic                dcr_write_valid;
    logic [AW-1:0]       dcr_write_addr;
    logic [DW-1:0]       dcr_write_data;
    logic [NUM_REQS-1:0] req_fire, rsp_fire;
    logic                req_gate, flush_valid, flush_ready, flush_done, busy;
    logic [SETS_W-1:0]   unified_cache_sets;
`ifdef CACHE_PART_PERF_EN
    logic [PCB-1:0]      perf_reconfigs, perf_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int model_sets = DEFAULT_SETS;
    int exp_flush = 0;
    int obs_flush = 0;
    int outst = 0;
    int last_sets = DEFAULT_SETS;
    bit mon_en = 0;
    int flush_mode = 1;    // 0 random, 1 immediate, 2 never ready, 3 ready then done 4 cycles later
    int traffic_mode = 0;  // 0 directed, 1 random, 2 responses only
    logic [NUM_REQS-1:0] dir_req = '0;
    logic [NUM_REQS-1:0] dir_rsp = '0;

    cache_partition_ctrl #(
        .NUM_REQS(NUM_REQS),
        .SETS_W(SETS_W),
        .MAX_SETS(MAX_SETS),
        .DEFAULT_SETS(DEFAULT_SETS),
        .OUTST_W(OUTST_W),
        .VX_DCR_ADDR_WIDTH(AW),
        .VX_DCR_DATA_WIDTH(DW),
        .VX_DCR_UNIFIED_CACHE_SETS(SET_ADDR)
`ifdef CACHE_PART_PERF_EN
        ,
        .PERF_CTR_BITS(PCB)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .dcr_write_valid(dcr_write_valid),
        .dcr_write_addr(dcr_write_addr),
        .dcr_write_data(dcr_write_data),
        .req_fire(req_fire),
        .rsp_fire(rsp_fire),
        .req_gate(req_gate),
        .flush_valid(flush_valid),
        .flush_ready(flush_ready),
        .flush_done(flush_done),
        .unified_cache_sets(unified_cache_sets),
        .busy(busy)
`ifdef CACHE_PART_PERF_EN
        ,
        .perf_reconfigs(perf_reconfigs),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampv(input int v);
        int d;
        d = v % 4096;
        return (d > int'(MAX_SETS)) ? int'(MAX_SETS) : d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dcr_drive(input logic [AW-1:0] a, input int v);
        dcr_write_valid = 1'b1;
        dcr_write_addr  = a;
        dcr_write_data  = DW'(v);
        tick();
        dcr_write_valid = 1'b0;
    endtask

    // Architectural effect of a single write issued while idle
    task automatic wr_expect(input int v);
        int c;
        c = clampv(v);
        if (c != model_sets) begin
            exp_q.push_back(c);
            exp_flush++;
            model_sets = c;
        end
        dcr_drive(SET_ADDR, v);
    endtask

    task automatic do_reset(input int n);
        if (model_sets != int'(DEFAULT_SETS)) exp_q.push_back(DEFAULT_SETS);
        model_sets = DEFAULT_SETS;
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, maxc);
        end
        tick();
    endtask

    // Flush responder
    initial begin
        bit waiting;
        int dly, d;
        bit go;
        flush_ready = 1'b0;
        flush_done  = 1'b0;
        waiting = 0;
        dly = 0;
        forever begin
            @(posedge clk);
            #1;
            flush_ready = 1'b0;
            flush_done  = 1'b0;
            if (reset) begin
                waiting = 0;
            end else if (waiting) begin
                if (dly == 0) begin
                    flush_done = 1'b1;
                    waiting = 0;
                end else begin
                    dly--;
                end
            end else if (flush_valid) begin
                go = 0;
                d = 0;
                case (flush_mode)
                    1: begin go = 1; d = 0; end
                    2: go = 0;
                    3: begin go = 1; d = 4; end
                    default: begin
                        go = ($urandom_range(0, 2) != 0);
                        d = $urandom_range(0, 3);
                    end
                endcase
                if (go) begin
                    flush_ready = 1'b1;
                    if (d == 0) flush_done = 1'b1;
                    else begin
                        waiting = 1;
                        dly = d - 1;
                    end
                end
            end
        end
    end

    // Core-side traffic; new requests honour the gate with one cycle of lag
    initial begin
        logic prev_gate, gate_last;
        logic [NUM_REQS-1:0] rq, rs;
        int navail;
        prev_gate = 1'b0;
        gate_last = 1'b0;
        req_fire = '0;
        rsp_fire = '0;
        forever begin
            @(posedge clk);
            #2;
            prev_gate = gate_last;
            gate_last = req_gate;
            if (traffic_mode == 0) begin
                req_fire = dir_req;
                rsp_fire = dir_rsp;
            end else begin
                rq = '0;
                rs = '0;
                if (traffic_mode == 1 && !prev_gate && outst < 20) begin
                    for (int i = 0; i < NUM_REQS; i++)
                        if ($urandom_range(0, 3) == 0) rq[i] = 1'b1;
                end
                navail = outst;
                for (int i = 0; i < NUM_REQS; i++) begin
                    if (navail > 0 && $urandom_range(0, 2) == 0) begin
                        rs[i] = 1'b1;
                        navail--;
                    end
                end
                req_fire = rq;
                rsp_fire = rs;
            end
        end
    end

    // Monitor: outstanding tracking, flush accounting, set-change scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset) outst = 0;
            else outst = outst + $countones(req_fire) - $countones(rsp_fire);
            if (mon_en && !reset) begin
                if (flush_valid) chk("flush_with_outstanding", outst, 0);
                if (flush_valid && flush_ready) obs_flush++;
                if (int'(unified_cache_sets) != last_sets) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sets_unexpected: got %0d expected no change from %0d",
                                 unified_cache_sets, last_sets);
                    end else begin
                        chk("sets_seq", int'(unified_cache_sets), exp_q.pop_front());
                    end
                    last_sets = int'(unified_cache_sets);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int fv, n, v;
        reset = 1'b1;
        dcr_write_valid = 1'b0;
        dcr_write_addr = '0;
        dcr_write_data = '0;
        repeat (3) tick();
        reset = 1'b0;

        @(negedge clk);
        chk("rst_sets", int'(unified_cache_sets), DEFAULT_SETS);
        chk("rst_gate", req_gate, 0);
        chk("rst_flush_valid", flush_valid, 0);
        chk("rst_busy", busy, 0);
        mon_en = 1;
        tick();

        // Minimum-latency reconfiguration to 8
        flush_mode = 1;
        exp_q.push_back(8);
        exp_flush++;
        model_sets = 8;
        dcr_write_valid = 1'b1;
        dcr_write_addr = SET_ADDR;
        dcr_write_data = 8;
        fv = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("t1_gate_c%0d", k), req_gate, int'(k >= 1 && k <= 4));
            chk($sformatf("t1_busy_c%0d", k), busy, int'(k >= 1 && k <= 4));
            chk($sformatf("t1_sets_c%0d", k), int'(unified_cache_sets), (k >= 4) ? 8 : 16);
            fv += int'(flush_valid);
            tick();
            if (k == 0) dcr_write_valid = 1'b0;
        end
        chk("t1_flush_pulses", fv, 1);

        // Write equal to current value: no sequence, one busy cycle
        do_reset(2);
        dcr_write_valid = 1'b1;
        dcr_write_data = 16;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t2_busy_c%0d", k), busy, int'(k == 1));
            chk($sformatf("t2_gate_c%0d", k), req_gate, 0);
            chk($sformatf("t2_flush_c%0d", k), flush_valid, 0);
            tick();
            if (k == 0) dcr_write_valid = 1'b0;
        end

        // Drain: 3 outstanding, a request in the gate cycle, responses trickle back
        dir_req = 4'b0111;
        tick();
        dir_req = '0;
        exp_q.push_back(4);
        exp_flush++;
        model_sets = 4;
        for (int k = 0; k < 10; k++) begin
            dcr_write_valid = (k == 0);
            dcr_write_data = 4;
            dir_req = (k == 1) ? 4'b0001 : 4'b0000;
            dir_rsp = (k == 3) ? 4'b0011 : (k == 5) ? 4'b0100 : (k == 7) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            chk($sformatf("t3_flush_c%0d", k), flush_valid, int'(k == 9));
            if (k >= 1) chk($sformatf("t3_gate_c%0d", k), req_gate, 1);
            tick();
        end
        dcr_write_valid = 1'b0;
        dir_req = '0;
        dir_rsp = '0;
        wait_idle(50);

        // Clamping and the all-scratch value
        wr_expect(100);
        wait_idle(50);
        chk("t4_clamp", int'(unified_cache_sets), 32);
        wr_expect(0);
        wait_idle(50);
        chk("t4_zero", int'(unified_cache_sets), 0);

        // Two overriding writes while waiting for flush completion
        flush_mode = 3;
        dcr_drive(SET_ADDR, 20);
        repeat (3) tick();
        exp_q.push_back(12);
        exp_flush++;
        model_sets = 12;
        dcr_drive(SET_ADDR, 8);
        dcr_drive(SET_ADDR, 12);
        wait_idle(50);
        chk("t5_sets", int'(unified_cache_sets), 12);
        repeat (4) tick();
        @(negedge clk);
        chk("t5_busy_after", busy, 0);
        chk("t5_flush_count", obs_flush, exp_flush);
        tick();

        // Reset while the flush request is held
        flush_mode = 2;
        dcr_drive(SET_ADDR, 8);
        n = 0;
        @(negedge clk);
        while (!flush_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_flush", flush_valid, 1);
        tick();
        do_reset(1);
        @(negedge clk);
        chk("t6_flush_valid", flush_valid, 0);
        chk("t6_gate", req_gate, 0);
        chk("t6_sets", int'(unified_cache_sets), 16);
        chk("t6_busy", busy, 0);
`ifdef CACHE_PART_PERF_EN
        chk("t6_perf_reconfigs", int'(perf_reconfigs), 0);
        chk("t6_perf_stall", int'(perf_stall_cycles), 0);
`endif
        flush_mode = 1;
        repeat (5) tick();
        @(negedge clk);
        chk("t6_busy_later", busy, 0);
        chk("t6_flush_count", obs_flush, exp_flush);
        tick();

        // Randomized writes with live traffic and random flush timing
        flush_mode = 0;
        traffic_mode = 1;
        for (int it = 0; it < 30; it++) begin
            wait_idle(300);
            v = ($urandom_range(0, 9) == 0) ? $urandom_range(33, 4095) : $urandom_range(0, 40);
            if ($urandom_range(0, 7) == 0) dcr_drive(SET_ADDR + 12'd1, v);
            else wr_expect(v);
        end
        wait_idle(300);
        traffic_mode = 2;
        n = 0;
        @(negedge clk);
        while (outst != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_traffic", outst, 0);
        tick();
        traffic_mode = 0;
        repeat (4) tick();

        @(negedge clk);
        chk("final_sets", int'(unified_cache_sets), model_sets);
        chk("final_flush_count", obs_flush, exp_flush);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
